sprite_commit_ctrl: RTL and testbench



---
 rtl/sprite_commit_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sprite_commit_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_commit_ctrl.sv
// sprite_commit_ctrl: buffers CPU register writes for the sprite renderer and
// replays them only during vertical blanking, so each frame sees a complete
// scene update (no sprite tearing, no position skew between objects).
module sprite_commit_ctrl #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned VACTIVE     = 480,
    parameter logic [8:0]  STATUS_ADDR = 9'h1FF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [8:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic [9:0]  vcount,
    output logic        reg_we,
    output logic [8:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        commit_done
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        StWait  = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] snap_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [7:0]      frame_cnt_q;

    logic [8:0]      mem_addr [DEPTH];
    logic [31:0]     mem_data [DEPTH];

    logic            vbl;
    logic            vbl_d_q;
    logic            armed_q;
    logic            rise;
    logic            fall;
    logic            full;
    logic            push;
    logic            pop;
    logic [5:0]      count_field;
    logic [31:0]     status_word;

    // Blanking edge detection. armed_q stays low after reset until active
    // video is seen, so a reset released mid-blank does not start a drain.
    assign vbl  = 32'(vcount) >= VACTIVE;
    assign rise = vbl && !vbl_d_q && armed_q;
    assign fall = !vbl && vbl_d_q;

    // Avalon side: stall only a write that finds the FIFO full.
    assign full        = (count_q == CntW'(DEPTH));
    assign waitrequest = chipselect && write && full;
    assign push        = chipselect && write && !full && (address != STATUS_ADDR);

    // Pop only while this frame's snapshot still has entries and blank persists.
    assign pop = (state_q == StDrain) && !fall && (snap_q != '0);

    // Status word: count is zero-extended (or truncated) into a 6-bit field.
    assign count_field = 6'(count_q);
    assign status_word = {16'd0, frame_cnt_q, state_q, count_field};

    // Blank edge history and arming after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vbl_d_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            vbl_d_q <= vbl;
            armed_q <= armed_q | !vbl;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave count as is.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= address;
            mem_data[wr_ptr_q] <= writedata;
        end
    end

    // Commit scheduler with registered renderer strobes and frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StWait;
            snap_q      <= '0;
            reg_we      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            commit_done <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            reg_we      <= 1'b0;
            commit_done <= 1'b0;
            unique case (state_q)
                StWait: begin
                    // Only entries present at blank start belong to this frame.
                    if (rise) begin
                        state_q <= StDrain;
                        snap_q  <= count_q;
                    end
                end
                StDrain: begin
                    if (snap_q != '0) begin
                        if (fall) begin
                            // Blank ended early: leftovers commit next frame.
                            state_q <= StWait;
                        end else begin
                            reg_we    <= 1'b1;
                            reg_addr  <= mem_addr[rd_ptr_q];
                            reg_wdata <= mem_data[rd_ptr_q];
                            snap_q    <= snap_q - CntW'(1);
                        end
                    end else begin
                        commit_done <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        state_q     <= fall ? StWait : StDone;
                    end
                end
                StDone: begin
                    if (fall) begin
                        state_q <= StWait;
                    end
                end
                default: begin
                    state_q <= StWait;
                end
            endcase
        end
    end

    // Read port, latency one; anything other than a status read returns zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (chipselect && read && (address == STATUS_ADDR)) begin
            readdata <= status_word;
        end else begin
            readdata <= '0;
        end
    end

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
// Bench for sprite_commit_ctrl: a scoreboard queue models the write FIFO,
// a negedge monitor records renderer strobes and commit pulses.
module tb_sprite_commit_ctrl;

    localparam int unsigned DEPTH       = 16;
    localparam logic [8:0]  STATUS_ADDR = 9'h1FF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [8:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [9:0]  vcount = 10'd100;
    logic        reg_we;
    logic [8:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        commit_done;

    sprite_commit_ctrl #(
        .DEPTH      (DEPTH),
        .VACTIVE    (480),
        .STATUS_ADDR(STATUS_ADDR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .waitrequest(waitrequest),
        .vcount     (vcount),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .commit_done(commit_done)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
        int          cyc;
    } obs_t;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          frames_exp = 0;
    logic [40:0] exp_q[$];
    obs_t        obs_q[$];
    int          done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record DUT outputs mid-cycle, tagged with the index of the last edge.
    always @(negedge clk) begin
        if (reg_we === 1'b1) obs_q.push_back('{addr: reg_addr, data: reg_wdata, cyc: cyc});
        if (commit_done === 1'b1) done_q.push_back(cyc);
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] status_word(input int fr, input int st, input int cnt);
        return {16'd0, 8'(fr), 2'(st), 6'(cnt)};
    endfunction

    task automatic av_write(input logic [8:0] a, input logic [31:0] d);
        int waited = 0;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        while (waitrequest === 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        if (waitrequest !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL av_write_timeout: waitrequest %b, want 0 within 200 cycles", waitrequest);
            step();
        end else begin
            step();
            if (a != STATUS_ADDR) exp_q.push_back({a, d});
        end
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic av_read(input logic [8:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        step();
        d          = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic enter_vblank(output int e0);
        vcount = 10'd480;
        step();
        e0 = cyc;
    endtask

    task automatic leave_vblank;
        vcount = 10'd100;
        step(2);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chipselect = 1'($urandom_range(0, 1));
            write      = 1'($urandom_range(0, 1));
            read       = 1'($urandom_range(0, 1));
            address    = 9'($urandom);
            writedata  = $urandom;
            vcount     = 10'($urandom_range(0, 524));
            step();
            n_checks++;
            if ({reg_we, commit_done, waitrequest} !== 3'b000 || reg_addr !== 9'd0 ||
                reg_wdata !== 32'd0 || readdata !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got we %b done %b wait %b addr %h wdata %h rdata %h, want all 0",
                         reg_we, commit_done, waitrequest, reg_addr, reg_wdata, readdata);
            end
        end
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        vcount     = 10'd100;
        step();
        reset_n = 1'b1;
        step(2);
        av_read(STATUS_ADDR, rd);
        n_checks++;
        if (rd !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL reset_status: got %h, want 00000000", rd);
        end
    endtask

    task automatic test_basic;
        logic [31:0] rd;
        logic [40:0] ee;
        obs_t        got;
        int          e0, nb, fd;
        av_write(9'd0, 32'h40);
        av_write(STATUS_ADDR, 32'hDEAD_BEEF);
        av_write(9'd1, 32'h60);
        av_write(9'd8, 32'h90);
        av_read(9'd5, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL basic_other_read: got %h, want 00000000", rd);
        end
        av_read(STATUS_ADDR, rd);
        n_checks++;
        if (rd !== status_word(frames_exp, 0, 3)) begin
            n_fail++;
            $display("FAIL basic_status_pre: got %h, want %h", rd, status_word(frames_exp, 0, 3));
        end
        nb = exp_q.size();
        obs_q.delete();
        done_q.delete();
        enter_vblank(e0);
        step(nb + 3);
        n_checks++;
        if (obs_q.size() !== nb) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes, want %0d", obs_q.size(), nb);
        end
        for (int i = 0; i < nb && obs_q.size() > 0; i++) begin
            ee  = exp_q.pop_front();
            got = obs_q.pop_front();
            n_checks++;
            if ({got.addr, got.data} !== ee || got.cyc !== e0 + i + 1) begin
                n_fail++;
                $display("FAIL basic_entry%0d: got %h/%h at E%0d, want %h/%h at E%0d", i,
                         got.addr, got.data, got.cyc - e0, ee[40:32], ee[31:0], i + 1);
            end
        end
        fd = (done_q.size() > 0) ? done_q[0] - e0 : -1;
        n_checks++;
        if (done_q.size() !== 1 || fd !== nb + 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses first at E%0d, want 1 at E%0d",
                     done_q.size(), fd, nb + 1);
        end
        frames_exp++;
        leave_vblank();
        av_read(STATUS_ADDR, rd);
        n_checks++;
        if (rd !== status_word(frames_exp, 0, 0)) begin
            n_fail++;
            $display("FAIL basic_status_post: got %h, want %h", rd, status_word(frames_exp, 0, 0));
        end
    endtask

    task automatic test_late_write;
        logic [40:0] ee;
        obs_t        got;
        int          e0, nb, fd;
        av_write(9'd2, 32'h11);
        av_write(9'd3, 32'h22);
        for (int f = 0; f < 2; f++) begin
            nb = (f == 0) ? 2 : 1;
            obs_q.delete();
            done_q.delete();
            enter_vblank(e0);
            // Write lands on E1, while the first pop is in flight.
            if (f == 0) av_write(9'd6, 32'h55);
            step(nb + 3);
            n_checks++;
            if (obs_q.size() !== nb) begin
                n_fail++;
                $display("FAIL late_count_f%0d: got %0d writes, want %0d", f, obs_q.size(), nb);
            end
            for (int i = 0; i < nb && obs_q.size() > 0; i++) begin
                ee  = exp_q.pop_front();
                got = obs_q.pop_front();
                n_checks++;
                if ({got.addr, got.data} !== ee || got.cyc !== e0 + i + 1) begin
                    n_fail++;
                    $display("FAIL late_entry_f%0d_%0d: got %h/%h at E%0d, want %h/%h at E%0d", f, i,
                             got.addr, got.data, got.cyc - e0, ee[40:32], ee[31:0], i + 1);
                end
            end
            fd = (done_q.size() > 0) ? done_q[0] - e0 : -1;
            n_checks++;
            if (done_q.size() !== 1 || fd !== nb + 1) begin
                n_fail++;
                $display("FAIL late_done_f%0d: got %0d pulses first at E%0d, want 1 at E%0d",
                         f, done_q.size(), fd, nb + 1);
            end
            frames_exp++;
            leave_vblank();
        end
    endtask

    task automatic test_full;
        logic [40:0] ee;
        obs_t        got;
        int          e0, nb, fd;
        for (int i = 0; i < DEPTH; i++) av_write(9'(i + 16), 32'hA000 + i);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 9'h0AA;
        writedata  = 32'hFEED;
        #1;
        n_checks++;
        if (waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL full_wait_set: got %b, want 1", waitrequest);
        end
        step(2);
        nb = exp_q.size();
        obs_q.delete();
        done_q.delete();
        enter_vblank(e0);
        n_checks++;
        if (waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL full_wait_e0: got %b, want 1", waitrequest);
        end
        step();
        n_checks++;
        if (waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL full_wait_e1: got %b, want 0", waitrequest);
        end
        step();
        exp_q.push_back({9'h0AA, 32'hFEED});
        chipselect = 1'b0;
        write      = 1'b0;
        step(nb + 2);
        n_checks++;
        if (obs_q.size() !== nb) begin
            n_fail++;
            $display("FAIL full_count: got %0d writes, want %0d", obs_q.size(), nb);
        end
        for (int i = 0; i < nb && obs_q.size() > 0; i++) begin
            ee  = exp_q.pop_front();
            got = obs_q.pop_front();
            n_checks++;
            if ({got.addr, got.data} !== ee || got.cyc !== e0 + i + 1) begin
                n_fail++;
                $display("FAIL full_entry%0d: got %h/%h at E%0d, want %h/%h at E%0d", i,
                         got.addr, got.data, got.cyc - e0, ee[40:32], ee[31:0], i + 1);
            end
        end
        fd = (done_q.size() > 0) ? done_q[0] - e0 : -1;
        n_checks++;
        if (done_q.size() !== 1 || fd !== nb + 1) begin
            n_fail++;
            $display("FAIL full_done: got %0d pulses first at E%0d, want 1 at E%0d",
                     done_q.size(), fd, nb + 1);
        end
        frames_exp++;
        leave_vblank();
        obs_q.delete();
        done_q.delete();
        enter_vblank(e0);
        step(4);
        ee = exp_q.pop_front();
        got = (obs_q.size() > 0) ? obs_q[0] : '0;
        n_checks++;
        if (obs_q.size() !== 1 || {got.addr, got.data} !== ee || got.cyc !== e0 + 1) begin
            n_fail++;
            $display("FAIL full_held_entry: got %0d writes, first %h/%h at E%0d, want 1 of %h/%h at E1",
                     obs_q.size(), got.addr, got.data, got.cyc - e0, ee[40:32], ee[31:0]);
        end
        frames_exp++;
        leave_vblank();
    endtask

    task automatic test_empty_vblank;
        logic [31:0] rd;
        int          e0, fd;
        obs_q.delete();
        done_q.delete();
        enter_vblank(e0);
        step(3);
        fd = (done_q.size() > 0) ? done_q[0] - e0 : -1;
        n_checks++;
        if (obs_q.size() !== 0 || done_q.size() !== 1 || fd !== 1) begin
            n_fail++;
            $display("FAIL empty_frame: got %0d writes, %0d pulses first at E%0d, want 0 writes, 1 at E1",
                     obs_q.size(), done_q.size(), fd);
        end
        frames_exp++;
        av_read(STATUS_ADDR, rd);
        n_checks++;
        if (rd !== status_word(frames_exp, 2, 0)) begin
            n_fail++;
            $display("FAIL empty_status_done: got %h, want %h", rd, status_word(frames_exp, 2, 0));
        end
        leave_vblank();
        av_read(STATUS_ADDR, rd);
        n_checks++;
        if (rd !== status_word(frames_exp, 0, 0)) begin
            n_fail++;
            $display("FAIL empty_status_wait: got %h, want %h", rd, status_word(frames_exp, 0, 0));
        end
    endtask

    task automatic test_reset_mid_drain;
        logic [31:0] rd;
        int          e0, fd;
        for (int i = 0; i < 5; i++) av_write(9'(i + 40), 32'hB000 + i);
        obs_q.delete();
        done_q.delete();
        enter_vblank(e0);
        step(2);
        n_checks++;
        if (reg_we !== 1'b1 || reg_addr !== 9'd41) begin
            n_fail++;
            $display("FAIL rst_pre_we: got we %b addr %h, want we 1 addr 029", reg_we, reg_addr);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (reg_we !== 1'b0 || commit_done !== 1'b0 || reg_addr !== 9'd0 || reg_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_outputs: got we %b done %b addr %h wdata %h, want all 0",
                     reg_we, commit_done, reg_addr, reg_wdata);
        end
        step(2);
        reset_n = 1'b1;
        exp_q.delete();
        frames_exp = 0;
        obs_q.delete();
        done_q.delete();
        step(6);
        n_checks++;
        if (obs_q.size() !== 0 || done_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rst_same_blank: got %0d writes %0d pulses, want 0 and 0",
                     obs_q.size(), done_q.size());
        end
        av_read(STATUS_ADDR, rd);
        n_checks++;
        if (rd !== status_word(0, 0, 0)) begin
            n_fail++;
            $display("FAIL rst_status: got %h, want %h", rd, status_word(0, 0, 0));
        end
        leave_vblank();
        obs_q.delete();
        done_q.delete();
        enter_vblank(e0);
        step(4);
        fd = (done_q.size() > 0) ? done_q[0] - e0 : -1;
        n_checks++;
        if (obs_q.size() !== 0 || done_q.size() !== 1 || fd !== 1) begin
            n_fail++;
            $display("FAIL rst_next_frame: got %0d writes, %0d pulses first at E%0d, want 0 writes, 1 at E1",
                     obs_q.size(), done_q.size(), fd);
        end
        frames_exp++;
        leave_vblank();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_late_write();
        test_full();
        test_empty_vblank();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
